lcd_fifo_ctrl: RTL and testbench
================================

# lcd_fifo_ctrl

Memory-mapped HD44780-style character-LCD controller, the parametrised successor to the single-shot LCD writer. It sits on the core's store/load strobe bus and buffers command and data bytes in a FIFO so the CPU never stalls on display timing. It generates setup, enable-pulse and hold phases and applies a per-command execution delay (short or long). It also enforces the power-on wait, exposes readable status, and lets software control the backlight.

## Interface
- BASEADDRESS, 32'h5000_0000: word-aligned base. Offset 0 = command, 1 = data, 2 = control/status.
- CLK_FREQ_HZ, 50_000_000: ACLK frequency; all delays are derived from it.
- FIFO_DEPTH, 16: entries, power of two, ≥2.
- SETUP_CYCLES, 4: RS/DATA stable before EN rises, ≥1.
- EN_PULSE_CYCLES, 25: EN high width, ≥1.
- HOLD_CYCLES, 4: EN low before next phase, ≥1.
- SHORT_DELAY_US, 50: execution wait after normal command/data.
- LONG_DELAY_US, 2000: wait after clear/home.
- INIT_DELAY_US, 15000: power-on wait before the first LCD access.

Ports:
- ACLK  in  1  clock.
- RESETN  in  1  asynchronous, active-low reset.
- DATA_I  in  32  write data; byte in [7:0].
- ADDR  in  32  byte address.
- WRSTB  in  1  single-cycle write strobe.
- RDSTB  in  1  single-cycle read strobe.
- DATA_O  out  32  read data, registered.
- LCD_BLON  out  1  backlight.
- LCD_DATA  inout  8  always driven by this block.
- LCD_EN, LCD_RS  out  1  enable / register select (0 = command).
- LCD_ON  out  1  constant 1.
- LCD_RW  out  1  constant 0.

## Operation
- Writes decode on WRSTB with ADDR in [BASE, BASE+2].
  - Offset 0 pushes {rs=0, DATA_I[7:0]}.
  - Offset 1 pushes {rs=1, DATA_I[7:0]}.
  - Offset 2 writes control: bit0=1 clears OVF; bit1 sets BLON.
- A push with the FIFO full is dropped and sets sticky OVF. Fullness is evaluated at the start of the cycle; a same-cycle pop does not make room.
- Reads on RDSTB at offset 2 load DATA_O next cycle with {BLON[9], OVF[8], FULL[7], BUSY[6], LEVEL[5:0]}. Any other address loads 0. BUSY = state≠IDLE or FIFO non-empty.
- FSM states:
  - INIT: counts INIT cycles, then goes to IDLE.
  - IDLE: if FIFO non-empty, pops, latches rs/byte onto LCD_RS/LCD_DATA, and goes to SETUP.
  - SETUP: SETUP_CYCLES with EN=0, then PULSE.
  - PULSE: EN_PULSE_CYCLES with EN=1, then HOLD.
  - HOLD: HOLD_CYCLES with EN=0, then WAIT.
  - WAIT: counts the delay, then IDLE.
- The long delay applies when rs=0 and byte[7:1]==0 (0x01 clear, 0x02/0x03 home). All other bytes use the short delay.
- Cycle counts are computed at elaboration: CLK_FREQ_HZ/1_000_000 × µs, rounded up, minimum 1. The counter is one down-counter sized by $clog2 of the largest count; phase exits when it reaches 0.
- LCD_DATA and LCD_RS hold their value after the transaction until the next pop.

## Timing
- Reset values:
  - state=INIT, FIFO empty, OVF=0.
  - LCD_EN=0, LCD_RS=0, LCD_DATA=0, LCD_BLON=1, DATA_O=0.
- RESETN assertion mid-transaction aborts immediately: EN drops asynchronously, the FIFO is flushed, and INIT restarts.
- Writes are accepted during INIT and queued.
- Pop-to-EN-rise = 1 + SETUP_CYCLES cycles. EN high exactly EN_PULSE_CYCLES.
- Next pop is no earlier than HOLD_CYCLES + delay after EN falls.
- Simultaneous push and pop on a non-full, non-empty FIFO: LEVEL unchanged.
- Push to an empty FIFO in IDLE is popped on the following cycle, never the same cycle.
- Pointers wrap modulo FIFO_DEPTH. LEVEL is $clog2(FIFO_DEPTH)+1 bits, zero-extended into [5:0].

## Structure
- Package lcd_pkg holds:
  - the state enum;
  - offset localparams CMD/DAT/CSR;
  - status bit positions;
  - a function us_to_cycles(freq, us).
- One sub-module, sync_fifo, is a parametrised width/depth FIFO with push, pop, full, empty and level. Width is 9 here: {rs, byte}.

## Test plan
Common parameters: CLK_FREQ_HZ=1_000_000, INIT=100µs, SHORT=5µs, LONG=40µs, SETUP=2, EN=3, HOLD=2, FIFO_DEPTH=4.
- Reset, then write CMD 0x38 at cycle 1 → no EN edge before cycle 100; EN high 3 cycles with RS=0, DATA=0x38.
- After init, CMD 0x01 then DAT 0x41 → EN of the second byte rises 2+40+1+2 cycles after the first EN falls; RS=1, DATA=0x41.
- After init, DAT 0x30 then DAT 0x31 → spacing governed by the 5-cycle short delay.
- During INIT write 5 bytes → 4 accepted; status read = OVF=1, FULL=1, LEVEL=4. Write CSR bit0 → OVF=0. The dropped fifth byte never appears on LCD_DATA.
- Write CSR 0x0 → LCD_BLON=0. Read CSR while a transaction is active → BUSY=1. Read CSR after drain → BUSY=0, LEVEL=0.
- Deassert RESETN during PULSE → LCD_EN=0 immediately, LEVEL=0, INIT wait restarts.

Source files
------------

// File: rtl/lcd_fifo_ctrl_pkg.sv
// lcd_pkg: shared types, register offsets, status layout and delay helper for lcd_fifo_ctrl
package lcd_pkg;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} lcd_state_t;
  localparam logic [1:0] CMD = 2'd0;
  localparam logic [1:0] DAT = 2'd1;
  localparam logic [1:0] CSR = 2'd2;
  localparam int BIT_BLON = 9;
  localparam int BIT_OVF  = 8;
  localparam int BIT_FULL = 7;
  localparam int BIT_BUSY = 6;
  localparam int LVL_W    = 6;
  function automatic int us_to_cycles(longint freq, longint us);
    longint c;
    c = (freq * us + 64'd999_999) / 64'd1_000_000;
    return c < 1 ? 1 : int'(c);
  endfunction
endpackage

// File: rtl/lcd_fifo_ctrl_if.sv
// lcd_fifo_ctrl_if: core store/load strobe bus
interface lcd_fifo_ctrl_if;
  logic [31:0] DATA_I;
  logic [31:0] ADDR;
  logic        WRSTB;
  logic        RDSTB;
  logic [31:0] DATA_O;
  modport master (output DATA_I, ADDR, WRSTB, RDSTB, input DATA_O);
  modport slave  (input DATA_I, ADDR, WRSTB, RDSTB, output DATA_O);
endinterface

// File: rtl/lcd_fifo_ctrl_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy level
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             ACLK,
  input  logic             RESETN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  always_ff @(posedge ACLK)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge ACLK or negedge RESETN)
    if (!RESETN) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr + AW'(do_push);
      rptr  <= rptr + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/lcd_fifo_ctrl.sv
// lcd_fifo_ctrl: memory-mapped, FIFO-buffered HD44780 character-LCD controller
module lcd_fifo_ctrl import lcd_pkg::*; #(
  parameter logic [31:0] BASEADDRESS = 32'h5000_0000,
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int FIFO_DEPTH      = 16,
  parameter int SETUP_CYCLES    = 4,
  parameter int EN_PULSE_CYCLES = 25,
  parameter int HOLD_CYCLES     = 4,
  parameter int SHORT_DELAY_US  = 50,
  parameter int LONG_DELAY_US   = 2000,
  parameter int INIT_DELAY_US   = 15000
) (
  input  logic       ACLK,
  input  logic       RESETN,
  lcd_fifo_ctrl_if.slave bus,
  output logic       LCD_BLON,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_ON,
  output logic       LCD_RW
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int INIT_C  = us_to_cycles(CLK_FREQ_HZ, INIT_DELAY_US);
  localparam int SHORT_C = us_to_cycles(CLK_FREQ_HZ, SHORT_DELAY_US);
  localparam int LONG_C  = us_to_cycles(CLK_FREQ_HZ, LONG_DELAY_US);
  localparam int M1      = INIT_C > LONG_C ? INIT_C : LONG_C;
  localparam int M2      = SHORT_C > M1 ? SHORT_C : M1;
  localparam int M3      = SETUP_CYCLES > M2 ? SETUP_CYCLES : M2;
  localparam int M4      = EN_PULSE_CYCLES > M3 ? EN_PULSE_CYCLES : M3;
  localparam int MAXC    = HOLD_CYCLES > M4 ? HOLD_CYCLES : M4;
  localparam int CW      = MAXC > 1 ? $clog2(MAXC) : 1;
  lcd_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] off, status;
  logic [AW:0] level;
  logic [8:0] fifo_dout;
  logic [7:0] data_q;
  logic wr_cmd, wr_dat, wr_csr, push, pop, full, empty, ovf, done, long_d;
  assign LCD_ON   = 1'b1;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;
  assign off    = bus.ADDR - BASEADDRESS;
  assign wr_cmd = bus.WRSTB && off == 32'(CMD);
  assign wr_dat = bus.WRSTB && off == 32'(DAT);
  assign wr_csr = bus.WRSTB && off == 32'(CSR);
  assign push   = wr_cmd || wr_dat;
  assign pop    = state == S_IDLE && !empty;
  assign done   = cnt == '0;
  // clear (0x01) and home (0x02/0x03) need the long execution time
  assign long_d = !LCD_RS && data_q[7:1] == 7'd0;
  sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .ACLK, .RESETN, .push, .pop,
    .din({wr_dat, bus.DATA_I[7:0]}),
    .dout(fifo_dout), .full, .empty, .level
  );
  always_comb begin
    status = '0;
    status[BIT_BLON]  = LCD_BLON;
    status[BIT_OVF]   = ovf;
    status[BIT_FULL]  = full;
    status[BIT_BUSY]  = state != S_IDLE || !empty;
    status[LVL_W-1:0] = LVL_W'(level);
  end
  always_comb begin
    state_n = state;
    cnt_n   = done ? cnt : cnt - CW'(1);
    case (state)
      S_INIT:  if (done) state_n = S_IDLE;
      S_IDLE:  if (!empty) begin state_n = S_SETUP; cnt_n = CW'(SETUP_CYCLES - 1); end
      S_SETUP: if (done) begin state_n = S_PULSE; cnt_n = CW'(EN_PULSE_CYCLES - 1); end
      S_PULSE: if (done) begin state_n = S_HOLD; cnt_n = CW'(HOLD_CYCLES - 1); end
      S_HOLD:  if (done) begin state_n = S_WAIT; cnt_n = long_d ? CW'(LONG_C - 1) : CW'(SHORT_C - 1); end
      S_WAIT:  if (done) state_n = S_IDLE;
      default: state_n = S_INIT;
    endcase
  end
  always_ff @(posedge ACLK or negedge RESETN)
    if (!RESETN) begin
      state      <= S_INIT;
      cnt        <= CW'(INIT_C - 1);
      LCD_EN     <= 1'b0;
      LCD_RS     <= 1'b0;
      data_q     <= '0;
      ovf        <= 1'b0;
      LCD_BLON   <= 1'b1;
      bus.DATA_O <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      LCD_EN <= state_n == S_PULSE;
      if (pop) {LCD_RS, data_q} <= fifo_dout;
      if (push && full) ovf <= 1'b1;
      else if (wr_csr && bus.DATA_I[0]) ovf <= 1'b0;
      if (wr_csr) LCD_BLON <= bus.DATA_I[1];
      if (bus.RDSTB) bus.DATA_O <= off == 32'(CSR) ? status : '0;
    end
endmodule

// File: tb/tb_lcd_fifo_ctrl.sv
// tb_lcd_fifo_ctrl: directed scenarios for lcd_fifo_ctrl with hand-computed expectations
module tb_lcd_fifo_ctrl;
  localparam logic [31:0] BASE = 32'h5000_0000;
  logic ACLK = 0, RESETN = 0;
  logic LCD_BLON, LCD_EN, LCD_RS, LCD_ON, LCD_RW;
  wire [7:0] LCD_DATA;
  int vec = 0, errs = 0, cyc = 0, rel = 0;
  int rise_q[$], fall_q[$];
  logic [7:0] dat_q[$];
  logic rs_q[$];
  logic en_prev = 0;
  lcd_fifo_ctrl_if bus();
  lcd_fifo_ctrl #(
    .BASEADDRESS(BASE), .CLK_FREQ_HZ(1_000_000), .FIFO_DEPTH(4),
    .SETUP_CYCLES(2), .EN_PULSE_CYCLES(3), .HOLD_CYCLES(2),
    .SHORT_DELAY_US(5), .LONG_DELAY_US(40), .INIT_DELAY_US(100)
  ) dut (
    .ACLK(ACLK), .RESETN(RESETN), .bus(bus.slave), .LCD_BLON(LCD_BLON),
    .LCD_DATA(LCD_DATA), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_ON(LCD_ON), .LCD_RW(LCD_RW)
  );
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc++;
  always @(posedge ACLK) begin
    #2;
    if (LCD_EN && !en_prev) begin
      rise_q.push_back(cyc);
      dat_q.push_back(LCD_DATA);
      rs_q.push_back(LCD_RS);
    end
    if (!LCD_EN && en_prev) fall_q.push_back(cyc);
    en_prev = LCD_EN;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic bus_wr(input logic [1:0] o, input logic [7:0] d);
    bus.ADDR = BASE + 32'(o); bus.DATA_I = {24'h0, d}; bus.WRSTB = 1;
    @(negedge ACLK);
    bus.WRSTB = 0;
  endtask
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    bus.ADDR = a; bus.RDSTB = 1;
    @(negedge ACLK);
    bus.RDSTB = 0;
    v = bus.DATA_O;
  endtask
  task automatic pulse_reset();
    RESETN = 0;
    repeat (2) @(negedge ACLK);
    RESETN = 1;
    rel = cyc;
  endtask
  task automatic wait_rises(input int n, input int budget, input string nm);
    int k = 0;
    while (rise_q.size() < n && k < budget) begin @(negedge ACLK); k++; end
    vec++;
    if (rise_q.size() < n) begin errs++; $display("FAIL %s: timeout, saw %0d EN rises, required %0d", nm, rise_q.size(), n); end
  endtask
  task automatic test_reset();
    logic [31:0] v;
    bus.ADDR = 0; bus.DATA_I = 0; bus.WRSTB = 0; bus.RDSTB = 0;
    RESETN = 0;
    repeat (3) @(negedge ACLK);
    vec++;
    if ({LCD_EN, LCD_RS, LCD_DATA, LCD_BLON, LCD_ON, LCD_RW} !== 13'b0_0_00000000_1_1_0) begin
      errs++; $display("FAIL reset_pins: got %b required 0_0_00000000_1_1_0", {LCD_EN, LCD_RS, LCD_DATA, LCD_BLON, LCD_ON, LCD_RW});
    end
    vec++;
    if (bus.DATA_O !== 32'h0) begin errs++; $display("FAIL reset_data_o: got %h required 0", bus.DATA_O); end
    RESETN = 1;
    rel = cyc;
    bus_rd(BASE + 2, v);
    vec++;
    if (v !== 32'h240) begin errs++; $display("FAIL reset_status: got %h required 240", v); end
  endtask
  task automatic test_init_cmd();
    int rb, fb;
    rb = rise_q.size(); fb = fall_q.size();
    pulse_reset();
    bus_wr(2'd0, 8'h38);
    wait_rises(rb + 1, 300, "init_rise");
    vec++;
    if (rise_q[rb] - rel !== 103) begin errs++; $display("FAIL init_rise_cycle: got %0d required 103", rise_q[rb] - rel); end
    vec++;
    if ({rs_q[rb], dat_q[rb]} !== 9'h038) begin errs++; $display("FAIL init_byte: got %h required 038", {rs_q[rb], dat_q[rb]}); end
    repeat (6) @(negedge ACLK);
    vec++;
    if (fall_q.size() <= fb || fall_q[fb] - rise_q[rb] !== 3) begin
      errs++; $display("FAIL init_en_width: got %0d required 3", fall_q.size() > fb ? fall_q[fb] - rise_q[rb] : -1);
    end
    repeat (20) @(negedge ACLK);
  endtask
  task automatic test_long_delay();
    int rb, fb;
    rb = rise_q.size(); fb = fall_q.size();
    bus_wr(2'd0, 8'h01);
    bus_wr(2'd1, 8'h41);
    wait_rises(rb + 2, 200, "long_rises");
    vec++;
    if ({rs_q[rb], dat_q[rb]} !== 9'h001) begin errs++; $display("FAIL long_first: got %h required 001", {rs_q[rb], dat_q[rb]}); end
    vec++;
    if (rise_q[rb + 1] - fall_q[fb] !== 45) begin errs++; $display("FAIL long_gap: got %0d required 45", rise_q[rb + 1] - fall_q[fb]); end
    vec++;
    if ({rs_q[rb + 1], dat_q[rb + 1]} !== 9'h141) begin errs++; $display("FAIL long_second: got %h required 141", {rs_q[rb + 1], dat_q[rb + 1]}); end
    repeat (20) @(negedge ACLK);
  endtask
  task automatic test_short_delay();
    int rb, fb, wc;
    rb = rise_q.size(); fb = fall_q.size(); wc = cyc;
    bus_wr(2'd1, 8'h30);
    bus_wr(2'd1, 8'h31);
    wait_rises(rb + 2, 100, "short_rises");
    vec++;
    if (rise_q[rb] - wc !== 4) begin errs++; $display("FAIL push_to_en: got %0d required 4", rise_q[rb] - wc); end
    vec++;
    if (rise_q[rb + 1] - fall_q[fb] !== 10) begin errs++; $display("FAIL short_gap: got %0d required 10", rise_q[rb + 1] - fall_q[fb]); end
    vec++;
    if ({dat_q[rb], dat_q[rb + 1]} !== 16'h3031) begin errs++; $display("FAIL short_bytes: got %h required 3031", {dat_q[rb], dat_q[rb + 1]}); end
    repeat (20) @(negedge ACLK);
  endtask
  task automatic test_back_to_back();
    int rb;
    logic [31:0] v;
    rb = rise_q.size();
    bus_wr(2'd1, 8'h61);
    bus_wr(2'd1, 8'h62);
    bus_rd(BASE + 2, v);
    vec++;
    if (v !== 32'h241) begin errs++; $display("FAIL push_pop_level: got %h required 241", v); end
    wait_rises(rb + 2, 100, "b2b_rises");
    vec++;
    if ({dat_q[rb], dat_q[rb + 1]} !== 16'h6162) begin errs++; $display("FAIL b2b_bytes: got %h required 6162", {dat_q[rb], dat_q[rb + 1]}); end
    repeat (20) @(negedge ACLK);
  endtask
  task automatic test_overflow();
    int rb;
    logic [31:0] v;
    logic [7:0] exp_b;
    rb = rise_q.size();
    pulse_reset();
    for (int i = 0; i < 5; i++) bus_wr(2'd1, 8'h50 + 8'(i));
    bus_rd(BASE + 2, v);
    vec++;
    if (v !== 32'h3c4) begin errs++; $display("FAIL ovf_status: got %h required 3c4", v); end
    bus_wr(2'd2, 8'h03);
    bus_rd(BASE + 2, v);
    vec++;
    if (v !== 32'h2c4) begin errs++; $display("FAIL ovf_clear: got %h required 2c4", v); end
    wait_rises(rb + 4, 400, "ovf_rises");
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h50 + 8'(i);
      vec++;
      if (dat_q[rb + i] !== exp_b) begin errs++; $display("FAIL ovf_byte%0d: got %h required %h", i, dat_q[rb + i], exp_b); end
    end
    repeat (40) @(negedge ACLK);
    vec++;
    if (rise_q.size() !== rb + 4) begin errs++; $display("FAIL ovf_dropped: got %0d rises required %0d", rise_q.size(), rb + 4); end
  endtask
  task automatic test_blon_busy();
    int rb;
    logic [31:0] v;
    rb = rise_q.size();
    bus_wr(2'd2, 8'h00);
    vec++;
    if (LCD_BLON !== 1'b0) begin errs++; $display("FAIL blon_off: got %b required 0", LCD_BLON); end
    bus_wr(2'd1, 8'h42);
    wait_rises(rb + 1, 50, "busy_rise");
    bus_rd(BASE + 2, v);
    vec++;
    if (v !== 32'h040) begin errs++; $display("FAIL busy_status: got %h required 040", v); end
    bus_rd(BASE + 3, v);
    vec++;
    if (v !== 32'h0) begin errs++; $display("FAIL read_out_of_range: got %h required 0", v); end
    repeat (30) @(negedge ACLK);
    bus_rd(BASE + 2, v);
    vec++;
    if (v !== 32'h0) begin errs++; $display("FAIL idle_status: got %h required 0", v); end
    bus_wr(2'd2, 8'h02);
    vec++;
    if (LCD_BLON !== 1'b1) begin errs++; $display("FAIL blon_on: got %b required 1", LCD_BLON); end
  endtask
  task automatic test_reset_mid();
    int rb, k;
    logic [31:0] v;
    bus_wr(2'd1, 8'h55);
    bus_wr(2'd1, 8'h56);
    k = 0;
    while (LCD_EN !== 1'b1 && k < 30) begin @(negedge ACLK); k++; end
    vec++;
    if (LCD_EN !== 1'b1) begin errs++; $display("FAIL mid_pulse_reach: got %b required 1", LCD_EN); end
    RESETN = 0;
    #1;
    vec++;
    if ({LCD_EN, LCD_DATA} !== 9'h000) begin errs++; $display("FAIL async_abort: got %h required 000", {LCD_EN, LCD_DATA}); end
    @(negedge ACLK);
    RESETN = 1;
    rel = cyc;
    rb = rise_q.size();
    bus_rd(BASE + 2, v);
    vec++;
    if (v !== 32'h240) begin errs++; $display("FAIL flush_status: got %h required 240", v); end
    bus_wr(2'd0, 8'h80);
    wait_rises(rb + 1, 300, "restart_rise");
    vec++;
    if (rise_q[rb] - rel !== 103) begin errs++; $display("FAIL restart_init: got %0d required 103", rise_q[rb] - rel); end
    vec++;
    if ({rs_q[rb], dat_q[rb]} !== 9'h080) begin errs++; $display("FAIL restart_byte: got %h required 080", {rs_q[rb], dat_q[rb]}); end
  endtask
  initial begin
    test_reset();
    test_init_cmd();
    test_long_delay();
    test_short_delay();
    test_back_to_back();
    test_overflow();
    test_blon_busy();
    test_reset_mid();
    repeat (5) @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
